// File: rtl/isqrt_pkg.sv
// isqrt_pkg: shared state encoding and rounding
// selectors for the streaming square-root engine.
package isqrt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } st_t;

  localparam int ROUND_TRUNC   = 0;
  localparam int ROUND_NEAREST = 1;

endpackage

// File: rtl/isqrt_nr_step.sv
// isqrt_nr_step: one non-restoring square-root
// iteration, purely combinational.
module isqrt_nr_step #(
  parameter int N = 16
) (
  input  logic [N+1:0] i_r,
  input  logic [N-1:0] i_q,
  input  logic [1:0]   i_pair,
  output logic [N+1:0] o_r,
  output logic [N-1:0] o_q
);

  logic [N+1:0] w_sh;
  logic [N+1:0] w_sub;
  logic [N+1:0] w_add;

  // The top two bits of r fall off the shift; the
  // signed remainder always fits in N+2 bits.
  assign w_sh  = {i_r[N-1:0], i_pair};
  assign w_sub = {i_q, 2'b01};
  assign w_add = {i_q, 2'b11};

  assign o_r = i_r[N+1] ? w_sh + w_add
                        : w_sh - w_sub;
  assign o_q = {i_q[N-2:0], ~o_r[N+1]};

endmodule

// File: rtl/isqrt_stream.sv
// isqrt_stream: valid/ready integer square root with
// floor remainder, optional rounding and tag passthrough.
module isqrt_stream
  import isqrt_pkg::*;
#(
  parameter int DIN_W = 32,
  parameter int TAG_W = 4,
  parameter int ROUND = ROUND_TRUNC
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DIN_W-1:0]   in_data,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DIN_W/2-1:0] out_root,
  output logic [DIN_W/2:0]   out_rem,
  output logic [TAG_W-1:0]   out_tag,
  output logic               busy,
  output logic [1:0]         cstate
);

  localparam int N  = DIN_W / 2;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  st_t              r_st;
  logic [DIN_W-1:0] r_x;
  logic [TAG_W-1:0] r_tag;
  logic [N+1:0]     r_r;
  logic [N-1:0]     r_q;
  logic [CW-1:0]    r_cnt;

  logic [N+1:0] w_r;
  logic [N-1:0] w_q;
  logic [N:0]   w_rf;
  logic         w_up;
  logic [N-1:0] w_root;

  isqrt_nr_step #(.N(N)) u_step (
    .i_r   (r_r),
    .i_q   (r_q),
    .i_pair(r_x[DIN_W-1 -: 2]),
    .o_r   (w_r),
    .o_q   (w_q)
  );

  // A negative final remainder is corrected back
  // to the floor remainder; it is never negative after.
  assign w_rf = r_r[N+1] ? r_r[N:0] + {r_q, 1'b1}
                         : r_r[N:0];
  assign w_up = w_rf > {1'b0, r_q};

  assign w_root =
    (ROUND == ROUND_NEAREST && w_up && !(&r_q))
      ? r_q + 1'b1 : r_q;

  assign in_ready = (r_st == IDLE);
  assign busy     = (r_st != IDLE);
  assign cstate   = r_st;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_st      <= IDLE;
      r_x       <= '0;
      r_tag     <= '0;
      r_r       <= '0;
      r_q       <= '0;
      r_cnt     <= '0;
      out_valid <= 1'b0;
      out_root  <= '0;
      out_rem   <= '0;
      out_tag   <= '0;
    end else begin
      unique case (r_st)
        IDLE: begin
          if (in_valid) begin
            r_x   <= in_data;
            r_tag <= in_tag;
            r_r   <= '0;
            r_q   <= '0;
            r_cnt <= '0;
            r_st  <= CALC;
          end
        end
        CALC: begin
          r_r   <= w_r;
          r_q   <= w_q;
          r_x   <= {r_x[DIN_W-3:0], 2'b00};
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST) r_st <= FIX;
        end
        FIX: begin
          out_root  <= w_root;
          out_rem   <= w_rf;
          out_tag   <= r_tag;
          out_valid <= 1'b1;
          r_st      <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            r_st      <= IDLE;
          end
        end
        default: r_st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_isqrt_stream.sv
// tb_isqrt_stream: directed cases plus a random valid/ready
// sweep over 8/16/32-bit engines against a reference model.
module tb_isqrt_stream;

  localparam int NI = 4;
  localparam int NS = 2500;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid  [NI];
  logic        in_ready  [NI];
  logic [31:0] in_data   [NI];
  logic [3:0]  in_tag    [NI];
  logic        out_valid [NI];
  logic        out_ready [NI];
  logic [15:0] out_root  [NI];
  logic [16:0] out_rem   [NI];
  logic [3:0]  out_tag   [NI];
  logic        busy      [NI];
  logic [1:0]  cstate    [NI];

  int cyc   = 0;
  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Instances: 0=32b floor, 1=32b round, 2=16b floor, 3=8b round
  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int W = (g < 2) ? 32 : ((g == 2) ? 16 : 8);
    localparam int R = (g == 1 || g == 3) ? 1 : 0;
    logic [W/2-1:0] w_root;
    logic [W/2:0]   w_rem;
    isqrt_stream #(.DIN_W(W), .TAG_W(4), .ROUND(R)) u_dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .in_valid (in_valid[g]),
      .in_ready (in_ready[g]),
      .in_data  (in_data[g][W-1:0]),
      .in_tag   (in_tag[g]),
      .out_valid(out_valid[g]),
      .out_ready(out_ready[g]),
      .out_root (w_root),
      .out_rem  (w_rem),
      .out_tag  (out_tag[g]),
      .busy     (busy[g]),
      .cstate   (cstate[g])
    );
    assign out_root[g] = 16'(w_root);
    assign out_rem[g]  = 17'(w_rem);
  end

  function automatic int wid(int g);
    return (g < 2) ? 32 : ((g == 2) ? 16 : 8);
  endfunction

  function automatic int rnd(int g);
    return (g == 1 || g == 3) ? 1 : 0;
  endfunction

  // Floor square root by bisection on plain integers.
  function automatic logic [63:0] fsqrt(logic [63:0] x);
    logic [63:0] lo, hi, m;
    lo = 0;
    hi = 64'd65536;
    while (hi - lo > 1) begin
      m = (lo + hi) / 2;
      if (m * m <= x) lo = m;
      else hi = m;
    end
    return lo;
  endfunction

  function automatic logic [63:0] eroot(logic [63:0] x,
                                        int w, int r);
    logic [63:0] q, top;
    q   = fsqrt(x);
    top = (64'd1 << (w / 2)) - 1;
    if (r != 0 && (x - q * q) > q && q < top) return q + 1;
    return q;
  endfunction

  task automatic chk(string tag, logic [63:0] got,
                     logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", tag, got, exp);
    end
  endtask

  task automatic chk_idle(string nm);
    chk({nm, ".ovalid"}, 64'(out_valid[0]), 0);
    chk({nm, ".root"},   64'(out_root[0]), 0);
    chk({nm, ".rem"},    64'(out_rem[0]), 0);
    chk({nm, ".tag"},    64'(out_tag[0]), 0);
    chk({nm, ".busy"},   64'(busy[0]), 0);
    chk({nm, ".cstate"}, 64'(cstate[0]), 0);
    chk({nm, ".iready"}, 64'(in_ready[0]), 1);
  endtask

  // One sample on a 32-bit instance, out_ready held high.
  task automatic xact(int g, logic [31:0] x, logic [3:0] t,
                      logic [63:0] er, logic [63:0] em,
                      string nm, output int ta);
    int tv, k;
    in_data[g]  = x;
    in_tag[g]   = t;
    in_valid[g] = 1'b1;
    k = 0;
    while (!in_ready[g] && k < 100) begin
      @(negedge clk);
      k++;
    end
    ta = cyc;
    @(negedge clk);
    in_valid[g] = 1'b0;
    k = 0;
    while (!out_valid[g] && k < 100) begin
      @(negedge clk);
      k++;
    end
    tv = cyc;
    chk({nm, ".lat"},  64'(tv - ta), 18);
    chk({nm, ".root"}, 64'(out_root[g]), er);
    chk({nm, ".rem"},  64'(out_rem[g]), em);
    chk({nm, ".tag"},  64'(out_tag[g]), 64'(t));
    @(negedge clk);
  endtask

  task automatic run_rand(int g);
    logic [63:0] px[$];
    logic [3:0]  pt[$];
    logic [63:0] x, q, r, mx;
    logic [3:0]  t;
    int w, sent, got, bud, sel;
    bit acc;
    w    = wid(g);
    mx   = (64'd1 << w) - 1;
    sent = 0;
    got  = 0;
    bud  = 0;
    acc  = 0;
    in_valid[g]  = 1'b0;
    out_ready[g] = 1'b0;
    while (got < NS && bud < NS * 30) begin
      @(negedge clk);
      bud++;
      out_ready[g] = ($urandom_range(0, 7) != 0);
      if (out_valid[g] && out_ready[g]) begin
        if (px.size() == 0) begin
          chk("rand.dup", 1, 0);
        end else begin
          x = px.pop_front();
          t = pt.pop_front();
          q = fsqrt(x);
          r = 64'(out_root[g]);
          chk("rand.root", r, eroot(x, w, rnd(g)));
          chk("rand.rem", 64'(out_rem[g]), x - q * q);
          chk("rand.tag", 64'(out_tag[g]), 64'(t));
          if (rnd(g) == 0)
            chk("rand.bound",
                64'(r * r <= x && (r + 1) * (r + 1) > x), 1);
        end
        got++;
      end
      if (acc) in_valid[g] = 1'b0;
      if (!in_valid[g] && sent < NS &&
          $urandom_range(0, 7) != 0) begin
        sel = $urandom_range(0, 15);
        x   = 64'($urandom) & mx;
        if (sel == 0) x = mx;
        if (sel == 1) x = 0;
        in_data[g]  = x[31:0];
        in_tag[g]   = 4'(sent);
        in_valid[g] = 1'b1;
      end
      acc = in_valid[g] && in_ready[g];
      if (acc) begin
        px.push_back(64'(in_data[g]) & mx);
        pt.push_back(in_tag[g]);
        sent++;
      end
    end
    chk("rand.count", 64'(got), 64'(NS));
    chk("rand.left", 64'(px.size()), 0);
    in_valid[g]  = 1'b0;
    out_ready[g] = 1'b0;
  endtask

  initial begin
    int ta0, ta1, k;
    logic [15:0] h_root;
    logic [16:0] h_rem;
    logic [3:0]  h_tag;
    reset_n = 1'b0;
    for (int g = 0; g < NI; g++) begin
      in_valid[g]  = 1'b0;
      in_data[g]   = '0;
      in_tag[g]    = '0;
      out_ready[g] = 1'b1;
    end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk_idle("reset");

    // Back-to-back floor results
    xact(0, 32'd0,   4'd1, 0,  0, "b2b0",   ta0);
    xact(0, 32'd1,   4'd2, 1,  0, "b2b1",   ta1);
    chk("b2b.thr", 64'(ta1 - ta0), 19);
    xact(0, 32'd144, 4'd3, 12, 0, "b2b144", ta0);
    xact(0, 32'd150, 4'd4, 12, 6, "b2b150", ta1);
    chk("b2b.thr2", 64'(ta1 - ta0), 19);

    // Rounding and saturation
    xact(1, 32'd156, 4'd6, 12, 12, "rnd156", ta0);
    xact(1, 32'd157, 4'd7, 13, 13, "rnd157", ta0);
    xact(1, 32'hFFFF_FFFF, 4'd8, 65535, 131070,
         "rndmax", ta0);
    xact(0, 32'hFFFF_FFFF, 4'd9, 65535, 131070,
         "trmax", ta0);

    // Backpressure
    out_ready[0] = 1'b0;
    in_data[0]   = 32'd81;
    in_tag[0]    = 4'd5;
    in_valid[0]  = 1'b1;
    k = 0;
    while (!in_ready[0] && k < 100) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    in_valid[0] = 1'b0;
    k = 0;
    while (!out_valid[0] && k < 100) begin
      @(negedge clk);
      k++;
    end
    h_root = out_root[0];
    h_rem  = out_rem[0];
    h_tag  = out_tag[0];
    chk("bp.root", 64'(h_root), 9);
    chk("bp.rem",  64'(h_rem), 0);
    chk("bp.tag",  64'(h_tag), 5);
    for (int i = 0; i < 5; i++) begin
      in_valid[0] = 1'b1;
      in_data[0]  = 32'd200;
      in_tag[0]   = 4'd7;
      @(negedge clk);
      chk("bp.hold.root", 64'(out_root[0]), 9);
      chk("bp.hold.rem",  64'(out_rem[0]), 0);
      chk("bp.hold.tag",  64'(out_tag[0]), 5);
      chk("bp.hold.ov",   64'(out_valid[0]), 1);
      chk("bp.hold.ir",   64'(in_ready[0]), 0);
      chk("bp.hold.st",   64'(cstate[0]), 3);
    end
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b1;
    @(negedge clk);
    chk("bp.rel.st", 64'(cstate[0]), 0);
    chk("bp.rel.ov", 64'(out_valid[0]), 0);
    @(negedge clk);
    chk("bp.noacc.st", 64'(cstate[0]), 0);

    // Reset during CALC iteration 7
    in_data[0]  = 32'd150;
    in_tag[0]   = 4'd10;
    in_valid[0] = 1'b1;
    @(negedge clk);
    in_valid[0] = 1'b0;
    repeat (7) @(negedge clk);
    chk("mid.busy", 64'(busy[0]), 1);
    reset_n = 1'b0;
    @(negedge clk);
    chk_idle("midrst");
    reset_n = 1'b1;
    @(negedge clk);
    xact(0, 32'd81, 4'd3, 9, 0, "post81", ta0);

    fork
      run_rand(0);
      run_rand(1);
      run_rand(2);
      run_rand(3);
    join

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/isqrt_stream.md
# isqrt_stream

Parametrised, handshaked integer square-root engine for the beamforming back end. It computes the floor or rounded square root of an unsigned DIN_W-bit sample (typically I²+Q² energy, for envelope detection) using a non-restoring, one-bit-per-cycle iteration. It also returns the exact remainder and passes a channel tag through alongside the result. It replaces the fixed 32-bit enable-driven root with valid/ready streaming, selectable rounding and per-sample channel tagging.

## Interface
- DIN_W, 32, input width; even, 4..64
- TAG_W, 4, sideband tag width (channel index); ≥1
- ROUND, 0, 0 = truncate (floor), 1 = round-to-nearest with saturation
- clk  in  1  single clock, rising edge
- reset_n  in  1  synchronous, active-low reset
- in_valid  in  1  sample offered
- in_ready  out  1  engine can accept; high only in IDLE
- in_data  in  DIN_W  radicand x, unsigned
- in_tag  in  TAG_W  channel tag, captured with in_data
- out_valid  out  1  result held
- out_ready  in  1  consumer accepts result
- out_root  out  DIN_W/2  root q
- out_rem  out  DIN_W/2+1  x − q_floor² (always the floor remainder)
- out_tag  out  TAG_W  tag of the sample producing this result
- busy  out  1  state ≠ IDLE
- cstate  out  2  current state encoding, for debug

## Operation
- States: IDLE=0, CALC=1, FIX=2, DONE=3.
- IDLE:
  - in_ready=1.
  - On in_valid: latch x and tag; clear r, q and the counter; go to CALC.
- CALC, N=DIN_W/2 iterations:
  - Signed partial remainder r, width N+2.
  - Each cycle: r ← {r,x[msb pair]} − {q,01} if r ≥ 0, else {r,x[msb pair]} + {q,11}.
  - Then q ← {q, r_new ≥ 0} and x shifts left by 2.
  - Leave for FIX after iteration N−1.
- FIX:
  - If r < 0, then r += {q,1}; the result is the floor remainder.
  - ROUND=1: if rem > q then q+1, saturated at 2^N−1. rem stays the floor remainder.
  - Register out_root, out_rem and out_tag. Go to DONE.
- DONE:
  - out_valid=1. Outputs stay stable while out_ready=0.
  - On out_ready, go to IDLE; out_valid drops on the next cycle.
- Registered outputs do not change outside FIX, except under reset.
- Reset (reset_n=0 at a clock edge):
  - state=IDLE.
  - out_valid=0, out_root=0, out_rem=0, out_tag=0, busy=0, cstate=0.
  - in_ready=1 from the first cycle after release.
  - Reset mid-CALC or mid-DONE discards the sample silently; no partial result is ever presented.

## Timing
- Accept at edge t (in_valid&in_ready). CALC occupies edges t+1..t+N, FIX is edge t+N+1, and out_valid is high after edge t+N+1.
- Latency is N+2 cycles: 18 for DIN_W=32.
- Throughput is one sample per N+3 cycles with out_ready tied high.
- in_ready is combinational from state only; there is no combinational path from in_valid or out_ready to any output.
- in_valid during CALC/FIX/DONE is ignored. The producer holds data, per the valid/ready rule.
- out_ready before out_valid has no effect.

## Structure
- Shared package isqrt_pkg holds the state enum (IDLE/CALC/FIX/DONE, 2-bit) and the ROUND_TRUNC/ROUND_NEAREST constants.
- Sub-module isqrt_nr_step is combinational: one non-restoring iteration (r, q, bit-pair → r', q'), parametrised by N. It is instanced once and reused per cycle.
- Control FSM, counter ($clog2(N+1) bits) and output registers live in isqrt_stream.

## Test plan
- DIN_W=32, ROUND=0, out_ready=1, back-to-back inputs 0, 1, 144, 150:
  - Results: root/rem 0/0, 1/0, 12/0, 12/6.
  - Each result 18 cycles after its accept; tags echoed.
- ROUND=1, inputs 156 and 157:
  - 156 → root 12, rem 12.
  - 157 → root 13, rem 13.
- ROUND=1, input 0xFFFFFFFF → root 65535 (saturated), rem 131070. With ROUND=0 → root 65535, rem 131070.
- Backpressure: out_ready=0 for 5 cycles after out_valid:
  - root/rem/tag stable, in_ready=0, a new in_valid is not accepted.
  - Release → IDLE next cycle.
- reset_n low for 1 cycle at CALC iteration 7:
  - All outputs read 0, cstate=0, in_ready=1.
  - The next sample 81 → 9/0 with the normal latency.
- Random sweep, 10k samples, DIN_W ∈ {8,16,32}, random valid/ready:
  - Check q² ≤ x < (q+1)² and rem = x − q².
  - Check tags are in order and no sample is lost or duplicated.
